// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// state encoding, digit width and the per-digit add-3 correction.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ADJUST = 2'd1,
    ST_SHIFT  = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Pre-shift correction so that a digit >= 5 carries into the next digit on shift.
  function automatic logic [BCD_DIGIT_W-1:0] add3_if_ge5(input logic [BCD_DIGIT_W-1:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One BCD digit's conditional add-3 step; purely combinational, no carry
// into neighbouring digits.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit_i,
  output logic [BCD_DIGIT_W-1:0] digit_o
);

  assign digit_o = add3_if_ge5(digit_i);

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter with start/busy/done handshake
// and overflow flag. Define BCD_SIGNED_EN for two's-complement input and out_sign.
module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_init,
  input  logic [IN_W-1:0]               in_bin,
  output logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd,
  output logic                          out_busy,
  output logic                          out_done,
  output logic                          out_ovf
`ifdef BCD_SIGNED_EN
  ,
  output logic                          out_sign
`endif
);

  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int SCR_W = BCD_DIGIT_W * DIGITS;

  state_e             state_q, state_d;
  logic [IN_W-1:0]    shift_q, shift_d;
  logic [SCR_W-1:0]   scratch_q, scratch_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               acc_q, acc_d;
  logic [SCR_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [SCR_W-1:0]   adj_scratch;
  logic [SCR_W-1:0]   shifted_scratch;
  logic [IN_W-1:0]    operand;

`ifdef BCD_SIGNED_EN
  logic sign_q, sign_d;
  logic out_sign_q, out_sign_d;

  // Unary minus wraps -2^(IN_W-1) onto itself, which read unsigned is 2^(IN_W-1).
  assign operand  = in_bin[IN_W-1] ? -in_bin : in_bin;
  assign out_sign = out_sign_q;
`else
  assign operand = in_bin;
`endif

  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_i(scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o(adj_scratch[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  assign shifted_scratch = {scratch_q[SCR_W-2:0], shift_q[IN_W-1]};

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    bcd_d     = bcd_q;
    ovf_d     = ovf_q;
`ifdef BCD_SIGNED_EN
    sign_d     = sign_q;
    out_sign_d = out_sign_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_init) begin
          shift_d   = operand;
          scratch_d = '0;
          acc_d     = 1'b0;
          cnt_d     = CNT_W'(IN_W);
`ifdef BCD_SIGNED_EN
          sign_d    = in_bin[IN_W-1];
`endif
          state_d   = ST_ADJUST;
        end
      end
      ST_ADJUST: begin
        scratch_d = adj_scratch;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        scratch_d = shifted_scratch;
        shift_d   = {shift_q[IN_W-2:0], 1'b0};
        // Any 1 leaving the top digit means the true result needs more digits.
        acc_d     = acc_q | scratch_q[SCR_W-1];
        cnt_d     = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          bcd_d   = shifted_scratch;
          ovf_d   = acc_q | scratch_q[SCR_W-1];
`ifdef BCD_SIGNED_EN
          out_sign_d = sign_q;
`endif
          state_d = ST_DONE;
        end else begin
          state_d = ST_ADJUST;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      scratch_q <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      bcd_q     <= '0;
      ovf_q     <= 1'b0;
`ifdef BCD_SIGNED_EN
      sign_q     <= 1'b0;
      out_sign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      bcd_q     <= bcd_d;
      ovf_q     <= ovf_d;
`ifdef BCD_SIGNED_EN
      sign_q     <= sign_d;
      out_sign_q <= out_sign_d;
`endif
    end
  end

  assign out_bcd  = bcd_q;
  assign out_ovf  = ovf_q;
  assign out_busy = (state_q == ST_ADJUST) || (state_q == ST_SHIFT);
  assign out_done = (state_q == ST_DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a 3-digit and a 2-digit instance share stimulus,
// each with its own expected-result queue and done-driven monitor.
module tb_bin2bcd_seq;

  localparam int IN_W = 8;

  logic        clk;
  logic        rst;
  logic        in_init;
  logic [7:0]  in_bin;
  logic [11:0] bcd3;
  logic [7:0]  bcd2;
  logic        busy3, done3, ovf3;
  logic        busy2, done2, ovf2;
`ifdef BCD_SIGNED_EN
  logic        sign3, sign2;
`endif

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(3)) dut3 (
    .clk(clk), .rst(rst), .in_init(in_init), .in_bin(in_bin),
    .out_bcd(bcd3), .out_busy(busy3), .out_done(done3), .out_ovf(ovf3)
`ifdef BCD_SIGNED_EN
    , .out_sign(sign3)
`endif
  );

  bin2bcd_seq #(.IN_W(IN_W), .DIGITS(2)) dut2 (
    .clk(clk), .rst(rst), .in_init(in_init), .in_bin(in_bin),
    .out_bcd(bcd2), .out_busy(busy2), .out_done(done2), .out_ovf(ovf2)
`ifdef BCD_SIGNED_EN
    , .out_sign(sign2)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] bcd3;
    logic        ovf3;
    logic [7:0]  bcd2;
    logic        ovf2;
    logic        sign;
  } exp_t;

  exp_t q3[$];
  exp_t q2[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] v);
    exp_t        e;
    int          m;
    logic [15:0] r;
    m      = int'(v);
    e.sign = 1'b0;
`ifdef BCD_SIGNED_EN
    if (v[7]) begin
      m      = 256 - int'(v);
      e.sign = 1'b1;
    end
`endif
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m           = m / 10;
    end
    e.bcd3 = r[11:0];
    e.ovf3 = |r[15:12];
    e.bcd2 = r[7:0];
    e.ovf2 = |r[15:8];
    return e;
  endfunction

  task automatic push(input logic [11:0] b3, input logic o3, input logic [7:0] b2,
                      input logic o2, input logic s);
    exp_t e;
    e.bcd3 = b3; e.ovf3 = o3; e.bcd2 = b2; e.ovf2 = o2; e.sign = s;
    q3.push_back(e);
    q2.push_back(e);
  endtask

  always @(negedge clk) begin
    if (done3) begin
      if (q3.size() == 0) begin
        chk("d3_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        chk("d3_bcd", 32'(bcd3), 32'(e.bcd3));
        chk("d3_ovf", 32'(ovf3), 32'(e.ovf3));
`ifdef BCD_SIGNED_EN
        chk("d3_sign", 32'(sign3), 32'(e.sign));
`endif
        $display("d3 done: bcd=%03h ovf=%0b", bcd3, ovf3);
      end
    end
  end

  always @(negedge clk) begin
    if (done2) begin
      if (q2.size() == 0) begin
        chk("d2_unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q2.pop_front();
        chk("d2_bcd", 32'(bcd2), 32'(e.bcd2));
        chk("d2_ovf", 32'(ovf2), 32'(e.ovf2));
`ifdef BCD_SIGNED_EN
        chk("d2_sign", 32'(sign2), 32'(e.sign));
`endif
      end
    end
  end

  // Called at a negedge with the DUT idle; returns at the negedge after DONE.
  task automatic convert(input logic [7:0] v);
    int cyc;
    int busy_cnt;
    bit seen;
    in_bin  = v;
    in_init = 1'b1;
    @(posedge clk);
    #1;
    in_init  = 1'b0;
    in_bin   = ~v;
    cyc      = 0;
    busy_cnt = 0;
    seen     = 1'b0;
    while (cyc < 100 && !seen) begin
      @(negedge clk);
      cyc++;
      if (busy3) busy_cnt++;
      if (done3) seen = 1'b1;
    end
    chk("done_seen", 32'(seen), 32'd1);
    if (seen) chk("done_latency", 32'(cyc - 1), 32'd16);
    chk("busy_cycles", 32'(busy_cnt), 32'd16);
    @(negedge clk);
  endtask

  task automatic directed(input logic [7:0] v, input logic [11:0] b3, input logic [7:0] b2,
                          input logic o2, input logic s);
    push(b3, 1'b0, b2, o2, s);
    convert(v);
  endtask

  initial begin
    int   busy_cnt;
    bit   seen;
    exp_t e;
    rst     = 1'b1;
    in_init = 1'b0;
    in_bin  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_bcd", 32'(bcd3), 32'd0);
    chk("rst_busy", 32'(busy3), 32'd0);
    chk("rst_done", 32'(done3), 32'd0);
    chk("rst_ovf", 32'(ovf3), 32'd0);
`ifdef BCD_SIGNED_EN
    chk("rst_sign", 32'(sign3), 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

`ifdef BCD_SIGNED_EN
    directed(8'h80, 12'h128, 8'h28, 1'b1, 1'b1);
    directed(8'hFF, 12'h001, 8'h01, 1'b0, 1'b1);
    directed(8'h7F, 12'h127, 8'h27, 1'b1, 1'b0);
    directed(8'd0,  12'h000, 8'h00, 1'b0, 1'b0);
    directed(8'd99, 12'h099, 8'h99, 1'b0, 1'b0);
    directed(8'd100, 12'h100, 8'h00, 1'b1, 1'b0);
`else
    directed(8'd255, 12'h255, 8'h55, 1'b1, 1'b0);
    directed(8'd0,   12'h000, 8'h00, 1'b0, 1'b0);
    directed(8'd9,   12'h009, 8'h09, 1'b0, 1'b0);
    directed(8'd10,  12'h010, 8'h10, 1'b0, 1'b0);
    directed(8'd99,  12'h099, 8'h99, 1'b0, 1'b0);
    directed(8'd100, 12'h100, 8'h00, 1'b1, 1'b0);
    directed(8'd128, 12'h128, 8'h28, 1'b1, 1'b0);
`endif

    // Requests during busy and during DONE must be dropped.
    push(12'h037, 1'b0, 8'h37, 1'b0, 1'b0);
    in_bin  = 8'd37;
    in_init = 1'b1;
    @(negedge clk);
    in_init  = 1'b0;
    busy_cnt = 1;
    while (busy_cnt < 5) begin
      @(negedge clk);
      busy_cnt++;
    end
    in_bin  = 8'd200;
    in_init = 1'b1;
    @(negedge clk);
    in_init = 1'b0;
    seen    = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done3) seen = 1'b1;
    end
    chk("ignore_done_seen", 32'(seen), 32'd1);
    in_init = 1'b1;
    @(negedge clk);
    in_init = 1'b0;
    repeat (40) @(negedge clk);
    chk("ignore_idle_busy", 32'(busy3), 32'd0);
    chk("ignore_result_held", 32'(bcd3), 32'h037);

    // Reset part-way through a conversion aborts it with no done pulse.
    in_bin  = 8'd173;
    in_init = 1'b1;
    @(negedge clk);
    in_init = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_busy_before", 32'(busy3), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(busy3), 32'd0);
    chk("abort_bcd", 32'(bcd3), 32'd0);
    chk("abort_done", 32'(done3), 32'd0);
    repeat (40) @(negedge clk);
    directed(8'd42, 12'h042, 8'h42, 1'b0, 1'b0);

    for (int v = 0; v < 256; v++) begin
      e = model(8'(v));
      push(e.bcd3, e.ovf3, e.bcd2, e.ovf2, e.sign);
      convert(8'(v));
    end

    repeat (4) @(negedge clk);
    chk("q3_drained", 32'(q3.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bin2bcd_seq.md
Name: bin2bcd_seq

Overview:
- Parametrised sequential binary-to-BCD converter using double-dabble (shift / add-3).
- Controller and datapath are integrated; converts an IN_W-bit binary word into DIGITS packed BCD digits.
- Sits between arithmetic results and display or UART formatting logic.
- Adds a start/busy/done handshake, registered outputs and overflow detection.

Parameters:
IN_W, 8, binary input width (2..32)
DIGITS, 3, number of BCD output digits (1..10)
CNT_W, $clog2(IN_W+1), bit-counter width (derived, not overridden)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
in_init  in  1  start request, sampled only in IDLE
in_bin  in  IN_W  binary operand, captured on accepted in_init
out_bcd  out  4*DIGITS  packed BCD result, digit 0 in [3:0]
out_busy  out  1  high while a conversion is in progress
out_done  out  1  one-cycle pulse when out_bcd/out_ovf are updated
out_ovf  out  1  result did not fit in DIGITS digits
out_sign  out  1  sign of operand (present only with BCD_SIGNED_EN)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: state=IDLE, out_bcd=0, out_busy=0, out_done=0, out_ovf=0, out_sign=0.
- Reset mid-conversion aborts immediately; no done pulse is produced.
- States:
  - IDLE: if in_init, capture in_bin into the shift register, clear scratch digits, clear the overflow accumulator, set count=IN_W, go to ADJUST. Otherwise stay.
  - ADJUST: in parallel, every scratch digit >=5 gets +3 (4-bit, no carry between digits). Go to SHIFT.
  - SHIFT: shift {scratch, shiftreg} left by 1; the bit leaving the top digit is ORed into the overflow accumulator; count-1.
    - If count becomes 0: go to DONE, and at the same edge load out_bcd with the shifted scratch and out_ovf with the accumulator.
    - Otherwise go to ADJUST.
  - DONE: out_done=1 for exactly this cycle, then go to IDLE.
- out_busy=1 in ADJUST and SHIFT, 0 in IDLE and DONE.
- Latency: in_init sampled at edge 0 gives out_done high during the cycle following edge 2*IN_W (16 cycles for IN_W=8).
- Throughput: one conversion per 2*IN_W+2 cycles.
- in_init outside IDLE (including during DONE) is ignored, not queued.
- in_bin is only sampled at acceptance; later changes have no effect.
- out_bcd and out_ovf hold their last result between conversions.
- Overflow: if out_ovf=1, out_bcd holds the low DIGITS digits of the true result.

Optional Feature:
- Macro: BCD_SIGNED_EN.
- Defined:
  - in_bin is two's complement.
  - At acceptance, magnitude = in_bin[IN_W-1] ? -in_bin : in_bin, as an IN_W-bit unsigned value; -2^(IN_W-1) maps correctly to 2^(IN_W-1).
  - out_sign is registered alongside out_bcd, reset 0.
- Undefined: in_bin is unsigned and the out_sign port does not exist.
- Latency is identical in both cases.

Decomposition:
- Package bcd_pkg:
  - state encoding constants ST_IDLE, ST_ADJUST, ST_SHIFT, ST_DONE (2-bit);
  - function add3_if_ge5 (4-bit in, 4-bit out);
  - BCD_DIGIT_W=4.
- Sub-module bcd_digit_adj: one digit's conditional add-3, instantiated DIGITS times in a generate loop.
- All else lives in bin2bcd_seq.

Test Plan:
- IN_W=8, DIGITS=3: rst, then in_init with in_bin=255 -> out_done pulses 16 cycles after acceptance; out_bcd=12'h255, out_ovf=0, out_busy high for 16 cycles.
- Boundary values 0, 9, 10, 99, 100, 128 -> out_bcd=12'h000, 009, 010, 099, 100, 128 respectively; exhaustive sweep 0..255 checked against a reference model.
- Start 37, then pulse in_init with in_bin=200 at cycle 5 of busy -> result 12'h037, exactly one done pulse, second request ignored.
- Assert rst at cycle 7 of a conversion of 173 -> out_busy=0, out_bcd=0, no out_done; a new conversion of 42 then yields 12'h042.
- DIGITS=2, in_bin=100 -> out_ovf=1, out_bcd=8'h00; in_bin=99 -> out_ovf=0, out_bcd=8'h99.
- BCD_SIGNED_EN, IN_W=8: in_bin=8'h80 -> out_sign=1, out_bcd=12'h128; 8'hFF -> out_sign=1, 12'h001; 8'h7F -> out_sign=0, 12'h127.
